// File: rtl/m_control_scoreboard_if.sv
// Issue-controller port bundle: decoder handshake, issue slot, writeback,
// flush and status. The controller is the slave side; the decoder/ALU
// environment is the master side.
interface m_control_scoreboard_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rs;
  logic [4:0] in_rq;
  logic [4:0] in_rd;
  logic       in_uses_rs;
  logic       in_uses_rq;
  logic       in_writes_rd;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] issue_rs;
  logic [4:0] issue_rq;
  logic [4:0] issue_rd;
  logic       issue_writes_rd;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       busy;
  logic       wb_err;

  modport slave (
    input  in_valid, in_rs, in_rq, in_rd, in_uses_rs, in_uses_rq, in_writes_rd,
    input  issue_ready, wb_valid, wb_rd, flush,
    output in_ready, issue_valid, issue_rs, issue_rq, issue_rd, issue_writes_rd,
    output busy, wb_err
  );

  modport master (
    output in_valid, in_rs, in_rq, in_rd, in_uses_rs, in_uses_rq, in_writes_rd,
    output issue_ready, wb_valid, wb_rd, flush,
    input  in_ready, issue_valid, issue_rs, issue_rq, issue_rd, issue_writes_rd,
    input  busy, wb_err
  );
endinterface

// File: rtl/m_control_scoreboard.sv
// Issue controller: register-write scoreboard with RAW/WAW and capacity
// stalls, a single registered issue slot, and flush-then-drain sequencing.
module m_control_scoreboard #(
  parameter int NREGS        = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input logic                  clk,
  input logic                  rst,
  m_control_scoreboard_if.slave bus
);
  typedef enum logic {RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [NREGS-1:0]     pending_q, pending_d, eff_pending;
  logic [CNT_W-1:0]     inflight_q, inflight_d, eff_inflight;
  logic                 issue_valid_q, issue_valid_d;
  logic [4:0]           issue_rs_q, issue_rs_d;
  logic [4:0]           issue_rq_q, issue_rq_d;
  logic [4:0]           issue_rd_q, issue_rd_d;
  logic                 issue_wr_q, issue_wr_d;
  logic                 wb_err_q;

  logic wb_hit, wb_clr, wb_spur, hazard, in_ready, accept, set_pend;

  // Writeback resolution: a completing write is visible to this cycle's
  // hazard check, so eff_* is the scoreboard as if the clear already happened.
  always_comb begin
    wb_hit       = bus.wb_valid && (bus.wb_rd != 5'd0);
    wb_clr       = wb_hit && pending_q[bus.wb_rd];
    wb_spur      = wb_hit && !pending_q[bus.wb_rd];
    eff_pending  = pending_q;
    if (wb_clr) eff_pending[bus.wb_rd] = 1'b0;
    eff_inflight = inflight_q - CNT_W'(wb_clr);
  end

  // Hazard detect and input handshake; r0 writes never stall or allocate.
  always_comb begin
    hazard   = (bus.in_uses_rs && eff_pending[bus.in_rs])
            || (bus.in_uses_rq && eff_pending[bus.in_rq])
            || (bus.in_writes_rd && (bus.in_rd != 5'd0) && eff_pending[bus.in_rd])
            || (bus.in_writes_rd && (bus.in_rd != 5'd0)
                && (eff_inflight == CNT_W'(MAX_INFLIGHT)));
    in_ready = (state_q == RUN) && !bus.flush && !hazard
            && (!issue_valid_q || bus.issue_ready);
    accept   = bus.in_valid && in_ready;
    set_pend = accept && bus.in_writes_rd && (bus.in_rd != 5'd0);
  end

  // Scoreboard next state: set wins over a same-cycle clear of the same rd,
  // and the counter nets +1/-1 to no change.
  always_comb begin
    pending_d  = eff_pending;
    if (set_pend) pending_d[bus.in_rd] = 1'b1;
    inflight_d = eff_inflight + CNT_W'(set_pend);
  end

  // Issue slot next state: flush empties it, accept reloads it (no bubble
  // when consumed in the same cycle), a bare consume empties it.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_rs_d    = issue_rs_q;
    issue_rq_d    = issue_rq_q;
    issue_rd_d    = issue_rd_q;
    issue_wr_d    = issue_wr_q;
    if ((state_q == RUN) && bus.flush) begin
      issue_valid_d = 1'b0;
    end else if (accept) begin
      issue_valid_d = 1'b1;
      issue_rs_d    = bus.in_rs;
      issue_rq_d    = bus.in_rq;
      issue_rd_d    = bus.in_rd;
      issue_wr_d    = bus.in_writes_rd;
    end else if (issue_valid_q && bus.issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  // FSM next state: flush enters DRAIN; DRAIN exits once all writes retire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush) state_d = DRAIN;
      DRAIN:   if (eff_inflight == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pending_q     <= '0;
      inflight_q    <= '0;
      issue_valid_q <= 1'b0;
      issue_rs_q    <= '0;
      issue_rq_q    <= '0;
      issue_rd_q    <= '0;
      issue_wr_q    <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      inflight_q    <= inflight_d;
      issue_valid_q <= issue_valid_d;
      issue_rs_q    <= issue_rs_d;
      issue_rq_q    <= issue_rq_d;
      issue_rd_q    <= issue_rd_d;
      issue_wr_q    <= issue_wr_d;
      wb_err_q      <= wb_spur;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.issue_valid     = issue_valid_q;
  assign bus.issue_rs        = issue_rs_q;
  assign bus.issue_rq        = issue_rq_q;
  assign bus.issue_rd        = issue_rd_q;
  assign bus.issue_writes_rd = issue_wr_q;
  assign bus.busy            = (state_q == DRAIN) || (inflight_q != '0);
  assign bus.wb_err          = wb_err_q;
endmodule

// File: tb/tb_m_control_scoreboard.sv
// Directed bench for the issue controller scoreboard.
module tb_m_control_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  m_control_scoreboard_if bus ();

  m_control_scoreboard #(.NREGS(32), .MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.in_valid = 0; bus.in_rs = 0; bus.in_rq = 0; bus.in_rd = 0;
    bus.in_uses_rs = 0; bus.in_uses_rq = 0; bus.in_writes_rd = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic put_wr(input logic [4:0] rd);
    bus.in_valid = 1; bus.in_rd = rd; bus.in_writes_rd = 1;
    bus.in_uses_rs = 0; bus.in_uses_rq = 0;
  endtask

  task automatic put_wb(input logic [4:0] rd);
    bus.wb_valid = 1; bus.wb_rd = rd;
  endtask

  task automatic test_reset();
    idle(); bus.issue_ready = 0; rst = 1;
    #2;
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0d exp=0", bus.issue_valid); end
    checks++; if (bus.issue_rd !== 5'd0) begin failures++; $display("FAIL reset_issue_rd got=%0d exp=0", bus.issue_rd); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", bus.busy); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%0d exp=0", bus.wb_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
    cyc(); rst = 0; cyc();
  endtask

  task automatic test_issue();
    idle(); bus.issue_ready = 0;
    bus.in_valid = 1; bus.in_rs = 1; bus.in_rq = 2; bus.in_rd = 3;
    bus.in_uses_rs = 1; bus.in_uses_rq = 1; bus.in_writes_rd = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL issue_in_ready got=%0d exp=1", bus.in_ready); end
    cyc(); idle();
    checks++; if (bus.issue_valid !== 1'b1) begin failures++; $display("FAIL issue_valid got=%0d exp=1", bus.issue_valid); end
    checks++; if ({bus.issue_rs, bus.issue_rq, bus.issue_rd} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL issue_fields got=%0d/%0d/%0d exp=1/2/3", bus.issue_rs, bus.issue_rq, bus.issue_rd); end
    checks++; if (bus.issue_writes_rd !== 1'b1) begin failures++; $display("FAIL issue_wr got=%0d exp=1", bus.issue_writes_rd); end
    checks++; if (dut.pending_q[3] !== 1'b1) begin failures++; $display("FAIL issue_pend3 got=%0d exp=1", dut.pending_q[3]); end
    checks++; if (dut.inflight_q !== 3'd1) begin failures++; $display("FAIL issue_inflight got=%0d exp=1", dut.inflight_q); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL issue_busy got=%0d exp=1", bus.busy); end
  endtask

  task automatic test_raw();
    idle(); bus.issue_ready = 1;
    bus.in_valid = 1; bus.in_rs = 3; bus.in_uses_rs = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%0d exp=0", bus.in_ready); end
    put_wb(3); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_bypass got=%0d exp=1", bus.in_ready); end
    cyc(); idle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rs !== 5'd3 || bus.issue_writes_rd !== 1'b0) begin failures++; $display("FAIL raw_issue got=%0d/%0d/%0d exp=1/3/0", bus.issue_valid, bus.issue_rs, bus.issue_writes_rd); end
    checks++; if (dut.inflight_q !== 3'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL raw_drained got=%0d/%0d exp=0/0", dut.inflight_q, bus.busy); end
    cyc();
    checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL raw_consume got=%0d exp=0", bus.issue_valid); end
  endtask

  task automatic test_capacity();
    idle(); bus.issue_ready = 1;
    for (int r = 1; r <= 4; r++) begin
      put_wr(5'(r)); #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cap_accept_%0d got=%0d exp=1", r, bus.in_ready); end
      cyc();
    end
    idle();
    checks++; if (dut.inflight_q !== 3'd4) begin failures++; $display("FAIL cap_full got=%0d exp=4", dut.inflight_q); end
    put_wr(5); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL cap_stall got=%0d exp=0", bus.in_ready); end
    put_wr(0); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cap_r0_write got=%0d exp=1", bus.in_ready); end
    idle(); bus.in_valid = 1; bus.in_rs = 6; bus.in_uses_rs = 1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cap_nonwrite got=%0d exp=1", bus.in_ready); end
    cyc(); idle();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rs !== 5'd6 || dut.inflight_q !== 3'd4) begin failures++; $display("FAIL cap_nonwrite_issue got=%0d/%0d/%0d exp=1/6/4", bus.issue_valid, bus.issue_rs, dut.inflight_q); end
    for (int r = 1; r <= 4; r++) begin put_wb(5'(r)); cyc(); end
    idle(); cyc();
    checks++; if (dut.inflight_q !== 3'd0 || dut.pending_q !== 32'd0) begin failures++; $display("FAIL cap_retire got=%0d/%h exp=0/0", dut.inflight_q, dut.pending_q); end
  endtask

  task automatic test_same_cycle();
    idle(); bus.issue_ready = 1;
    put_wr(7); cyc(); idle();
    checks++; if (dut.pending_q[7] !== 1'b1 || dut.inflight_q !== 3'd1) begin failures++; $display("FAIL same_setup got=%0d/%0d exp=1/1", dut.pending_q[7], dut.inflight_q); end
    put_wr(7); put_wb(7); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%0d exp=1", bus.in_ready); end
    cyc(); idle();
    checks++; if (dut.pending_q[7] !== 1'b1 || dut.inflight_q !== 3'd1) begin failures++; $display("FAIL same_set_wins got=%0d/%0d exp=1/1", dut.pending_q[7], dut.inflight_q); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL same_no_err got=%0d exp=0", bus.wb_err); end
    put_wb(7); cyc(); idle(); cyc();
    checks++; if (dut.inflight_q !== 3'd0) begin failures++; $display("FAIL same_retire got=%0d exp=0", dut.inflight_q); end
  endtask

  task automatic test_wb_err();
    idle(); bus.issue_ready = 1;
    put_wb(9); cyc(); idle();
    checks++; if (bus.wb_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%0d exp=1", bus.wb_err); end
    checks++; if (dut.inflight_q !== 3'd0 || dut.pending_q !== 32'd0) begin failures++; $display("FAIL err_nochange got=%0d/%h exp=0/0", dut.inflight_q, dut.pending_q); end
    cyc();
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%0d exp=0", bus.wb_err); end
    put_wb(0); cyc(); idle();
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL err_r0 got=%0d exp=0", bus.wb_err); end
  endtask

  task automatic test_flush();
    idle(); bus.issue_ready = 1;
    put_wr(10); cyc(); put_wr(11); cyc();
    idle(); bus.issue_ready = 0;
    checks++; if (bus.issue_valid !== 1'b1 || dut.inflight_q !== 3'd2) begin failures++; $display("FAIL flush_setup got=%0d/%0d exp=1/2", bus.issue_valid, dut.inflight_q); end
    bus.flush = 1; cyc(); bus.flush = 0;
    put_wr(20); #1;
    checks++; if (bus.issue_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL flush_drain got=%0d/%0d/%0d exp=0/0/1", bus.issue_valid, bus.in_ready, bus.busy); end
    bus.flush = 1; put_wb(10); cyc(); bus.flush = 0; bus.wb_valid = 0; #1;
    checks++; if (bus.in_ready !== 1'b0 || dut.inflight_q !== 3'd1) begin failures++; $display("FAIL flush_mid got=%0d/%0d exp=0/1", bus.in_ready, dut.inflight_q); end
    put_wb(11); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_last_wb got=%0d exp=0", bus.in_ready); end
    cyc(); bus.wb_valid = 0; bus.in_valid = 0; #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL flush_resume got=%0d/%0d exp=1/0", bus.in_ready, bus.busy); end
    // Reset while draining.
    idle(); put_wr(12); cyc(); idle();
    bus.flush = 1; cyc(); bus.flush = 0;
    checks++; if (bus.busy !== 1'b1 || bus.issue_rd !== 5'd12) begin failures++; $display("FAIL rstdrain_setup got=%0d/%0d exp=1/12", bus.busy, bus.issue_rd); end
    #2; rst = 1; #1;
    checks++; if (bus.busy !== 1'b0 || bus.issue_valid !== 1'b0 || bus.issue_rd !== 5'd0 || bus.issue_writes_rd !== 1'b0 || bus.wb_err !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstdrain got=%0d/%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0/1", bus.busy, bus.issue_valid, bus.issue_rd, bus.issue_writes_rd, bus.wb_err, bus.in_ready); end
    checks++; if (dut.pending_q !== 32'd0 || dut.inflight_q !== 3'd0) begin failures++; $display("FAIL rstdrain_sb got=%h/%0d exp=0/0", dut.pending_q, dut.inflight_q); end
    cyc(); rst = 0; cyc();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_raw();
    test_capacity();
    test_same_cycle();
    test_wb_err();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
